ps2_rx_ctrl: RTL and testbench

Sequencing controller for the PS/2 keyboard input path of the DINO game. Synchronises raw `kb_clk`/`kb_data` into the `clk` domain and frames each 11-bit PS/2 packet with a state machine. Checks start, parity and stop bits and applies an inter-bit timeout. Folds `E0` (extended) and `F0` (break) prefixes into single key events, delivers them to game logic over a one-entry valid/ready buffer, and maintains held-key levels for jump and duck.

---
 rtl/ps2_rx_ctrl.sv | 169 ++++++++++++++++
 tb/tb_ps2_rx_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_ctrl.sv
// PS/2 keyboard receiver: synchronises kb_clk/kb_data, frames 11-bit packets, folds E0/F0 prefixes
// into key events behind a one-entry valid/ready buffer. Define PS2_RX_PARITY_CHECK_EN to reject bad parity.
module ps2_rx_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 5000,
  parameter logic [7:0]  JUMP_CODE      = 8'h29,
  parameter logic [7:0]  DUCK_CODE      = 8'h72
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kb_clk,
  input  logic       kb_data,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_break,
  output logic       evt_ext,
  output logic       jump,
  output logic       duck,
  output logic       err_frame,
  output logic       err_ovf
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef PS2_RX_PARITY_CHECK_EN
  localparam bit PAR_CHK = 1'b1;
`else
  localparam bit PAR_CHK = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t          state, state_next;
  logic            clk_s1, clk_s2, clk_d, dat_s1, dat_s2;
  logic            fall;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            par_bit;
  logic [CW-1:0]   cnt;
  logic            shift_en, bit_clr, par_en, frame_good, frame_bad, timeout_hit, parity_ok;
  logic            byte_rdy, bad_q;
  logic [7:0]      byte_q;
  logic            ext_f, brk_f;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s1 <= 1'b0;
      clk_s2 <= 1'b0;
      clk_d  <= 1'b0;
      dat_s1 <= 1'b0;
      dat_s2 <= 1'b0;
    end else begin
      clk_s1 <= kb_clk;
      clk_s2 <= clk_s1;
      clk_d  <= clk_s2;
      dat_s1 <= kb_data;
      dat_s2 <= dat_s1;
    end
  end

  assign fall      = clk_d & ~clk_s2;
  assign parity_ok = ^{shreg, par_bit};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next  = state;
    shift_en    = 1'b0;
    bit_clr     = 1'b0;
    par_en      = 1'b0;
    frame_good  = 1'b0;
    frame_bad   = 1'b0;
    timeout_hit = (state != IDLE) && !fall && (cnt == CW'(TIMEOUT_CYCLES));
    case (state)
      IDLE: if (fall) begin
        if (!dat_s2) begin
          state_next = DATA;
          bit_clr    = 1'b1;
        end else begin
          frame_bad = 1'b1;
        end
      end
      DATA: if (fall) begin
        shift_en = 1'b1;
        if (bit_cnt == 3'd7) state_next = PARITY;
      end
      PARITY: if (fall) begin
        par_en     = 1'b1;
        state_next = STOP;
      end
      STOP: if (fall) begin
        state_next = IDLE;
        if (dat_s2 && (parity_ok || !PAR_CHK)) frame_good = 1'b1;
        else                                  frame_bad  = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    if (timeout_hit) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      cnt      <= '0;
      byte_rdy <= 1'b0;
      byte_q   <= '0;
      bad_q    <= 1'b0;
    end else begin
      if (bit_clr)       bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
      if (shift_en) shreg   <= {dat_s2, shreg[7:1]};
      if (par_en)   par_bit <= dat_s2;
      if (fall || state == IDLE)        cnt <= '0;
      else if (cnt != CW'(TIMEOUT_CYCLES)) cnt <= cnt + 1'b1;
      byte_rdy <= frame_good;
      bad_q    <= frame_bad;
      if (frame_good) byte_q <= shreg;
    end
  end

  // Decoder and output stage run one cycle behind framing so all outputs move together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_f     <= 1'b0;
      brk_f     <= 1'b0;
      evt_valid <= 1'b0;
      evt_code  <= '0;
      evt_break <= 1'b0;
      evt_ext   <= 1'b0;
      jump      <= 1'b0;
      duck      <= 1'b0;
      err_frame <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      err_frame <= bad_q | timeout_hit;
      err_ovf   <= 1'b0;
      if (timeout_hit) begin
        ext_f <= 1'b0;
        brk_f <= 1'b0;
      end
      if (evt_valid && evt_ready) evt_valid <= 1'b0;
      if (byte_rdy) begin
        if (byte_q == 8'hE0) begin
          ext_f <= 1'b1;
        end else if (byte_q == 8'hF0) begin
          brk_f <= 1'b1;
        end else begin
          ext_f <= 1'b0;
          brk_f <= 1'b0;
          if (byte_q == JUMP_CODE && !ext_f) jump <= !brk_f;
          if (byte_q == DUCK_CODE &&  ext_f) duck <= !brk_f;
          if (!evt_valid || evt_ready) begin
            evt_valid <= 1'b1;
            evt_code  <= byte_q;
            evt_break <= brk_f;
            evt_ext   <= ext_f;
          end else begin
            err_ovf <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Directed self-checking bench for ps2_rx_ctrl (short timeout for fast simulation).
module tb_ps2_rx_ctrl;
  localparam int unsigned TO = 200;

  logic       clk = 1'b0, rst = 1'b0, kb_clk = 1'b1, kb_data = 1'b1, evt_ready = 1'b1;
  logic       evt_valid, evt_break, evt_ext, jump, duck, err_frame, err_ovf;
  logic [7:0] evt_code;

  int checks = 0, errors = 0;
  int fe_cnt = 0, ov_cnt = 0;
  int rd = 0;
  logic [9:0] ev_log[$];

  ps2_rx_ctrl #(.TIMEOUT_CYCLES(TO), .JUMP_CODE(8'h29), .DUCK_CODE(8'h72)) dut (
    .clk(clk), .rst(rst), .kb_clk(kb_clk), .kb_data(kb_data),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_break(evt_break), .evt_ext(evt_ext), .jump(jump), .duck(duck),
    .err_frame(err_frame), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst && evt_valid && evt_ready) ev_log.push_back({evt_code, evt_break, evt_ext});
    if (err_frame) fe_cnt++;
    if (err_ovf)   ov_cnt++;
  end

  task automatic half();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      kb_data = bits[i];
      half();
      kb_clk = 1'b0;
      half();
      kb_clk = 1'b1;
    end
    kb_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic bad_par);
    logic [10:0] f;
    f = {1'b1, (~^d) ^ bad_par, d, 1'b0};
    send_bits(f, 11);
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({evt_valid, evt_code, evt_break, evt_ext, jump, duck, err_frame, err_ovf} !== 14'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", {evt_valid, evt_code, evt_break, evt_ext, jump, duck, err_frame, err_ovf});
    end
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_make_jump();
    int fe0;
    fe0 = fe_cnt;
    send_byte(8'h29, 1'b0);
    checks++;
    if (ev_log.size() != rd + 1 || ev_log[rd] !== {8'h29, 2'b00}) begin
      errors++; $display("FAIL make_jump_evt: got n=%0d %h want n=1 %h", ev_log.size() - rd, ev_log[rd], {8'h29, 2'b00});
    end
    rd = ev_log.size();
    checks++;
    if (jump !== 1'b1) begin errors++; $display("FAIL make_jump_level: got %b want 1", jump); end
    checks++;
    if (fe_cnt != fe0) begin errors++; $display("FAIL make_jump_err: got %0d want 0", fe_cnt - fe0); end
  endtask

  task automatic test_break_jump();
    send_byte(8'hF0, 1'b0);
    checks++;
    if (ev_log.size() != rd) begin errors++; $display("FAIL f0_alone: got %0d events want 0", ev_log.size() - rd); end
    send_byte(8'h29, 1'b0);
    checks++;
    if (ev_log.size() != rd + 1 || ev_log[rd] !== {8'h29, 2'b10}) begin
      errors++; $display("FAIL break_jump_evt: got n=%0d %h want n=1 %h", ev_log.size() - rd, ev_log[rd], {8'h29, 2'b10});
    end
    rd = ev_log.size();
    checks++;
    if (jump !== 1'b0) begin errors++; $display("FAIL break_jump_level: got %b want 0", jump); end
  endtask

  task automatic test_ext_duck();
    send_byte(8'hE0, 1'b0);
    send_byte(8'h72, 1'b0);
    checks++;
    if (ev_log.size() != rd + 1 || ev_log[rd] !== {8'h72, 2'b01}) begin
      errors++; $display("FAIL duck_make_evt: got n=%0d %h want n=1 %h", ev_log.size() - rd, ev_log[rd], {8'h72, 2'b01});
    end
    rd = ev_log.size();
    checks++;
    if (duck !== 1'b1) begin errors++; $display("FAIL duck_make_level: got %b want 1", duck); end
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h72, 1'b0);
    checks++;
    if (ev_log.size() != rd + 1 || ev_log[rd] !== {8'h72, 2'b11}) begin
      errors++; $display("FAIL duck_break_evt: got n=%0d %h want n=1 %h", ev_log.size() - rd, ev_log[rd], {8'h72, 2'b11});
    end
    rd = ev_log.size();
    checks++;
    if (duck !== 1'b0) begin errors++; $display("FAIL duck_break_level: got %b want 0", duck); end
    send_byte(8'h72, 1'b0);
    checks++;
    if (ev_log.size() != rd + 1 || ev_log[rd] !== {8'h72, 2'b00}) begin
      errors++; $display("FAIL plain72_evt: got n=%0d %h want n=1 %h", ev_log.size() - rd, ev_log[rd], {8'h72, 2'b00});
    end
    rd = ev_log.size();
    checks++;
    if (duck !== 1'b0) begin errors++; $display("FAIL plain72_duck: got %b want 0", duck); end
  endtask

  task automatic test_parity();
    int fe0;
    fe0 = fe_cnt;
    send_byte(8'h29, 1'b1);
`ifdef PS2_RX_PARITY_CHECK_EN
    checks++;
    if (fe_cnt != fe0 + 1) begin errors++; $display("FAIL parity_err: got %0d pulses want 1", fe_cnt - fe0); end
    checks++;
    if (ev_log.size() != rd) begin errors++; $display("FAIL parity_noevt: got %0d events want 0", ev_log.size() - rd); end
    checks++;
    if (jump !== 1'b0) begin errors++; $display("FAIL parity_jump: got %b want 0", jump); end
`else
    checks++;
    if (fe_cnt != fe0) begin errors++; $display("FAIL parity_ignored_err: got %0d pulses want 0", fe_cnt - fe0); end
    checks++;
    if (ev_log.size() != rd + 1 || ev_log[rd] !== {8'h29, 2'b00}) begin
      errors++; $display("FAIL parity_ignored_evt: got n=%0d %h want n=1 %h", ev_log.size() - rd, ev_log[rd], {8'h29, 2'b00});
    end
    rd = ev_log.size();
    send_byte(8'hF0, 1'b0);
    send_byte(8'h29, 1'b0);
    rd = ev_log.size();
`endif
  endtask

  task automatic test_bad_start();
    int fe0;
    fe0 = fe_cnt;
    send_bits(11'h001, 1);
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (fe_cnt != fe0 + 1) begin errors++; $display("FAIL bad_start_err: got %0d pulses want 1", fe_cnt - fe0); end
    checks++;
    if (ev_log.size() != rd) begin errors++; $display("FAIL bad_start_noevt: got %0d events want 0", ev_log.size() - rd); end
  endtask

  task automatic test_timeout();
    logic [10:0] f;
    int k, fe0;
    send_byte(8'hE0, 1'b0);
    fe0 = fe_cnt;
    f = {1'b1, 1'b1, 8'h55, 1'b0};
    k = 0;
    for (int unsigned i = 0; i < 5; i++) begin
      kb_data = f[i];
      half();
      kb_clk = 1'b0;
      if (i < 4) begin
        half();
        kb_clk = 1'b1;
      end
    end
    for (int j = 1; j <= int'(TO) + 50; j++) begin
      @(negedge clk);
      if (err_frame) begin k = j; break; end
    end
    kb_clk = 1'b1;
    kb_data = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (k != int'(TO) + 5) begin errors++; $display("FAIL timeout_latency: got %0d want %0d", k, TO + 5); end
    checks++;
    if (fe_cnt != fe0 + 1) begin errors++; $display("FAIL timeout_pulse: got %0d cycles want 1", fe_cnt - fe0); end
    send_byte(8'h1B, 1'b0);
    checks++;
    if (ev_log.size() != rd + 1 || ev_log[rd] !== {8'h1B, 2'b00}) begin
      errors++; $display("FAIL timeout_recover: got n=%0d %h want n=1 %h", ev_log.size() - rd, ev_log[rd], {8'h1B, 2'b00});
    end
    rd = ev_log.size();
  endtask

  task automatic test_overflow();
    int ov0;
    ov0 = ov_cnt;
    evt_ready = 1'b0;
    send_byte(8'h29, 1'b0);
    send_byte(8'h1B, 1'b0);
    checks++;
    if (evt_valid !== 1'b1 || evt_code !== 8'h29 || evt_break !== 1'b0 || evt_ext !== 1'b0) begin
      errors++; $display("FAIL ovf_hold: got v=%b %h want v=1 29", evt_valid, evt_code);
    end
    checks++;
    if (ov_cnt != ov0 + 1) begin errors++; $display("FAIL ovf_pulse: got %0d cycles want 1", ov_cnt - ov0); end
    checks++;
    if (jump !== 1'b1) begin errors++; $display("FAIL ovf_jump: got %b want 1", jump); end
    evt_ready = 1'b1;
    @(posedge clk);
    #1;
    evt_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b want 0", evt_valid); end
    checks++;
    if (ev_log.size() != rd + 1 || ev_log[rd] !== {8'h29, 2'b00}) begin
      errors++; $display("FAIL drain_evt: got n=%0d %h want n=1 %h", ev_log.size() - rd, ev_log[rd], {8'h29, 2'b00});
    end
    rd = ev_log.size();
  endtask

  task automatic test_reset_midframe();
    send_byte(8'h1B, 1'b0);
    send_bits({1'b1, 1'b0, 8'h29, 1'b0}, 3);
    kb_data = 1'b0;
    half();
    kb_clk = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if ({evt_valid, evt_code, evt_break, evt_ext, jump, duck, err_frame, err_ovf} !== 14'h0) begin
      errors++;
      $display("FAIL midframe_reset: got %h want 0", {evt_valid, evt_code, evt_break, evt_ext, jump, duck, err_frame, err_ovf});
    end
    kb_clk = 1'b1;
    kb_data = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    evt_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rd = ev_log.size();
    send_byte(8'h1B, 1'b0);
    checks++;
    if (ev_log.size() != rd + 1 || ev_log[rd] !== {8'h1B, 2'b00}) begin
      errors++; $display("FAIL post_reset_evt: got n=%0d %h want n=1 %h", ev_log.size() - rd, ev_log[rd], {8'h1B, 2'b00});
    end
    rd = ev_log.size();
  endtask

  initial begin
    test_reset();
    test_make_jump();
    test_break_jump();
    test_ext_duck();
    test_parity();
    test_bad_start();
    test_timeout();
    test_overflow();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
